sgpr_rf: RTL and testbench
==========================

Name: sgpr_rf

Overview:
Shadow general-purpose register file: 16 x 32-bit registers with one synchronous write port and two combinational read ports. The full register array is also driven out in parallel on rf_reg, so a fault-tolerance / checkpoint controller can snapshot or compare core state. It sits beside the core's main register file and mirrors its write traffic.

Parameters:
ADDR_WIDTH, 5, width of the read and write address ports
DATA_WIDTH, 32, register word width
NUM_WORDS, 16, number of implemented registers (RV32E-style x0..x15)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
test_en_i  input  1  test-mode enable; no functional effect in this flip-flop implementation
raddr_a_i  input  5  read port A address
rdata_a_o  output  32  read port A data
raddr_b_i  input  5  read port B address
rdata_b_o  output  32  read port B data
waddr_a_i  input  5  write address
wdata_a_i  input  32  write data
we_a_i  input  1  write enable
rf_reg  output  16x32 (packed [15:0][31:0])  live contents of all registers; rf_reg[i] = register i

Behaviour:
- Storage: registers 1..15 are 32-bit flip-flops. Register 0 is hardwired to 0.
- Reset: on a rising clk edge with rst_n=0, registers 1..15 clear to 0. Reset has priority over a simultaneous write.
- After reset, all of rdata_a_o, rdata_b_o and rf_reg read 0 until a write occurs.
- Write: on a rising clk edge with rst_n=1 and we_a_i=1, the addressed register loads wdata_a_i when waddr_a_i is in 1..15.
- The new value is visible on the read ports and on rf_reg immediately after that edge (write latency 1 edge).
- Ignored writes, with no state change:
  - waddr_a_i = 0 (register 0 stays 0).
  - waddr_a_i in 16..31 (bit 4 set; out of range).
  - we_a_i = 0.
- Read: rdata_a_o and rdata_b_o are purely combinational, 0 cycles latency.
  - Return register[raddr] for raddr 0..15 (0 for raddr 0).
  - Return 32'h0 for raddr 16..31.
- Read-during-write to the same address returns the old (pre-edge) value; there is no write-to-read bypass.
- Both read ports are independent. They may address the same register or the write target simultaneously.
- rf_reg is driven continuously from the storage, with rf_reg[0] = 0. It is not registered separately and tracks the array with no extra delay.
- test_en_i is accepted and ignored. Outputs must be identical for test_en_i = 0 and 1.
- Any write data pattern is legal; no arithmetic or width conversion is performed.

Test Plan:
- Reset: hold rst_n=0 for one edge, then rst_n=1, we_a_i=0 -> rf_reg[0..15] all 0; rdata_a_o=rdata_b_o=0 for addresses 0, 5 and 15.
- Back-to-back writes:
  - Stimulus: we=1, waddr=10, wdata=100 for one edge; then waddr=11, wdata=103 with raddr_a=10 for one edge; then we=0, raddr_a=10.
  - Required: rf_reg[10]=100 after the first edge; rdata_a_o=100; rf_reg[11]=103 after the second edge; rf_reg[12] unchanged at 0.
- x0 and out-of-range:
  - Stimulus: write 32'hDEADBEEF to address 0, then to address 20.
  - Required: rf_reg unchanged; rdata_a_o for raddr 0 and for raddr 20 both 0.
- Read-during-write:
  - Setup: reg5=7.
  - Stimulus: same cycle, write wdata=9 to addr 5 with raddr_a=5, raddr_b=5.
  - Required: both ports show 7 before the edge and 9 after it.
- Reset priority:
  - Setup: reg3=55.
  - Stimulus: assert rst_n=0 together with we=1, waddr=3, wdata=77.
  - Required: reg3=0 after the edge.
- Write enable and test_en_i:
  - Stimulus: we=0 with waddr=4, wdata=1 -> reg4 unchanged.
  - Stimulus: toggle test_en_i during writes -> results identical to test_en_i=0.

Source files
------------

// File: rtl/sgpr_rf.sv
// sgpr_rf: shadow register file, 16x32, x0 hardwired to zero, full array exported on rf_reg
module sgpr_rf #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  test_en_i,
  input  logic [ADDR_WIDTH-1:0]                 raddr_a_i,
  output logic [DATA_WIDTH-1:0]                 rdata_a_o,
  input  logic [ADDR_WIDTH-1:0]                 raddr_b_i,
  output logic [DATA_WIDTH-1:0]                 rdata_b_o,
  input  logic [ADDR_WIDTH-1:0]                 waddr_a_i,
  input  logic [DATA_WIDTH-1:0]                 wdata_a_i,
  input  logic                                  we_a_i,
  output logic [NUM_WORDS-1:0][DATA_WIDTH-1:0]  rf_reg
);
  localparam int IW = $clog2(NUM_WORDS);
  logic [NUM_WORDS-1:1][DATA_WIDTH-1:0] mem_q, mem_d;
  logic unused_test_en;
  logic wr_ok;
  assign unused_test_en = test_en_i;
  assign wr_ok = we_a_i && waddr_a_i[ADDR_WIDTH-1:IW] == '0 && waddr_a_i[IW-1:0] != '0;
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[waddr_a_i[IW-1:0]] = wdata_a_i;
  end
  always_ff @(posedge clk) mem_q <= !rst_n ? '0 : mem_d;
  assign rf_reg    = {mem_q, {DATA_WIDTH{1'b0}}};
  assign rdata_a_o = raddr_a_i[ADDR_WIDTH-1:IW] == '0 ? rf_reg[raddr_a_i[IW-1:0]] : '0;
  assign rdata_b_o = raddr_b_i[ADDR_WIDTH-1:IW] == '0 ? rf_reg[raddr_b_i[IW-1:0]] : '0;
endmodule

// File: tb/tb_sgpr_rf.sv
// tb_sgpr_rf: scoreboard-based directed bench for sgpr_rf
module tb_sgpr_rf;
  logic clk = 0;
  logic rst_n = 0;
  logic test_en_i = 0;
  logic [4:0] raddr_a_i = 0, raddr_b_i = 0, waddr_a_i = 0;
  logic [31:0] wdata_a_i = 0;
  logic we_a_i = 0;
  logic [31:0] rdata_a_o, rdata_b_o;
  logic [15:0][31:0] rf_reg;
  logic [31:0] mdl [16];
  logic [31:0] exp_q [$];
  string tag_q [$];
  int n_err = 0, n_chk = 0;
  sgpr_rf dut (
    .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
    .raddr_a_i(raddr_a_i), .rdata_a_o(rdata_a_o),
    .raddr_b_i(raddr_b_i), .rdata_b_o(rdata_b_o),
    .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i), .we_a_i(we_a_i),
    .rf_reg(rf_reg)
  );
  always #5 clk = ~clk;
  task automatic push(string t, logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask
  task automatic pop_chk(logic [31:0] obs);
    string t;
    logic [31:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    n_chk++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", t, obs, e);
    end
  endtask
  function automatic logic [31:0] mrd(logic [4:0] a);
    return a < 16 ? mdl[a[3:0]] : 32'h0;
  endfunction
  task automatic chk_all(string t);
    for (int i = 0; i < 16; i++) push($sformatf("%s rf_reg[%0d]", t, i), mdl[i]);
    for (int i = 0; i < 16; i++) pop_chk(rf_reg[i]);
  endtask
  task automatic chk_rd(string t, logic [4:0] a, logic [4:0] b);
    raddr_a_i = a;
    raddr_b_i = b;
    #1;
    push($sformatf("%s rdata_a[%0d]", t, a), mrd(a));
    push($sformatf("%s rdata_b[%0d]", t, b), mrd(b));
    pop_chk(rdata_a_o);
    pop_chk(rdata_b_o);
  endtask
  task automatic wr(logic we, logic [4:0] a, logic [31:0] d, logic te);
    we_a_i = we;
    waddr_a_i = a;
    wdata_a_i = d;
    test_en_i = te;
    @(posedge clk);
    if (we && a != 0 && a < 16) mdl[a[3:0]] = d;
    #1;
    we_a_i = 0;
    test_en_i = 0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    chk_all("reset");
    chk_rd("reset", 0, 5);
    chk_rd("reset", 15, 15);
    raddr_a_i = 0;
    wr(1, 10, 100, 0);
    push("b2b rf_reg[10]", 100);
    pop_chk(rf_reg[10]);
    raddr_a_i = 10;
    wr(1, 11, 103, 0);
    #1;
    push("b2b rdata_a", 100);
    pop_chk(rdata_a_o);
    push("b2b rf_reg[11]", 103);
    pop_chk(rf_reg[11]);
    push("b2b rf_reg[12]", 0);
    pop_chk(rf_reg[12]);
    wr(1, 0, 32'hDEADBEEF, 0);
    wr(1, 20, 32'hDEADBEEF, 0);
    wr(1, 26, 32'hCAFEF00D, 0);
    chk_all("x0_oor");
    chk_rd("x0_oor", 0, 20);
    wr(1, 15, 32'hA5A5_5A5A, 0);
    chk_rd("alias", 31, 15);
    chk_rd("alias", 26, 10);
    wr(1, 5, 7, 0);
    raddr_a_i = 5;
    raddr_b_i = 5;
    we_a_i = 1;
    waddr_a_i = 5;
    wdata_a_i = 9;
    #1;
    push("rdw pre a", 7);
    push("rdw pre b", 7);
    pop_chk(rdata_a_o);
    pop_chk(rdata_b_o);
    @(posedge clk);
    mdl[5] = 9;
    #1;
    we_a_i = 0;
    push("rdw post a", 9);
    push("rdw post b", 9);
    pop_chk(rdata_a_o);
    pop_chk(rdata_b_o);
    wr(0, 4, 1, 0);
    push("we0 rf_reg[4]", 0);
    pop_chk(rf_reg[4]);
    for (int i = 0; i < 40; i++)
      wr(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, 1'($urandom));
    chk_all("rand_te");
    for (int i = 0; i < 8; i++) chk_rd("rand_te", 5'($urandom), 5'($urandom));
    wr(1, 3, 55, 0);
    push("rst_pri pre", 55);
    pop_chk(rf_reg[3]);
    rst_n = 0;
    we_a_i = 1;
    waddr_a_i = 3;
    wdata_a_i = 77;
    @(posedge clk);
    for (int i = 0; i < 16; i++) mdl[i] = 0;
    #1;
    rst_n = 1;
    we_a_i = 0;
    chk_all("rst_pri");
    chk_rd("rst_pri", 3, 11);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
